// File: rtl/key_pkg.sv
// Shared types and defaults for the vertical-steering key conditioning path.
package key_pkg;

  typedef enum logic {OWN_PLUS, OWN_MINUS} owner_t;

  localparam int unsigned DEFAULT_DEBOUNCE = 250000;

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-flop synchronizer, stable-sample debounce counter and
// press-edge pulse.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic resetN,
  input  logic rawN,
  output logic deb,
  output logic pressPulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          synced;
  logic [CW-1:0] cnt;
  logic          deb_d1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
    end else begin
      sync1  <= ~rawN;
      synced <= sync1;
    end
  end

  // Any sample equal to the accepted level restarts the count.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (synced == deb) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      deb <= synced;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      deb_d1     <= 1'b0;
      pressPulse <= 1'b0;
    end else begin
      deb_d1     <= deb;
      pressPulse <= deb & ~deb_d1;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Plus/minus key conditioning: per-key debounce, last-pressed arbitration,
// sticky taps and frame-aligned request levels for the vertical mover.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic keyPlusN,
  input  logic keyMinusN,
  output logic plusIsPressed,
  output logic minusIsPressed,
  output logic plusPulse,
  output logic minusPulse
);

  logic   deb_plus;
  logic   deb_minus;
  logic   deb_plus_d1;
  logic   deb_minus_d1;
  logic   rise_plus;
  logic   rise_minus;
  owner_t owner;
  logic   sticky_plus;
  logic   sticky_minus;
  logic   arb_plus;
  logic   arb_minus;
  logic   want_plus;
  logic   want_minus;
  logic   frame_plus;
  logic   frame_minus;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_plus (
    .clk        (clk),
    .resetN     (resetN),
    .rawN       (keyPlusN),
    .deb        (deb_plus),
    .pressPulse (plusPulse)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_minus (
    .clk        (clk),
    .resetN     (resetN),
    .rawN       (keyMinusN),
    .deb        (deb_minus),
    .pressPulse (minusPulse)
  );

  // Local edge detect so owner/sticky update on the same edge as the pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      deb_plus_d1  <= 1'b0;
      deb_minus_d1 <= 1'b0;
    end else begin
      deb_plus_d1  <= deb_plus;
      deb_minus_d1 <= deb_minus;
    end
  end

  always_comb begin
    rise_plus  = deb_plus & ~deb_plus_d1;
    rise_minus = deb_minus & ~deb_minus_d1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      owner <= OWN_PLUS;
    end else if (rise_plus && !rise_minus) begin
      owner <= OWN_PLUS;
    end else if (rise_minus && !rise_plus) begin
      owner <= OWN_MINUS;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sticky_plus  <= 1'b0;
      sticky_minus <= 1'b0;
    end else begin
      sticky_plus  <= rise_plus | (sticky_plus & ~startOfFrame);
      sticky_minus <= rise_minus | (sticky_minus & ~startOfFrame);
    end
  end

  always_comb begin
    arb_plus    = deb_plus & (~deb_minus | (owner == OWN_PLUS));
    arb_minus   = deb_minus & (~deb_plus | (owner == OWN_MINUS));
    want_plus   = arb_plus | (sticky_plus & ~arb_minus);
    want_minus  = arb_minus | (sticky_minus & ~arb_plus);
    frame_plus  = want_plus;
    frame_minus = want_minus;
    // Two pending taps with nothing held: last-pressed key takes the frame.
    if (want_plus && want_minus) begin
      frame_plus  = (owner == OWN_PLUS);
      frame_minus = (owner == OWN_MINUS);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      plusIsPressed  <= 1'b0;
      minusIsPressed <= 1'b0;
    end else if (startOfFrame) begin
      plusIsPressed  <= frame_plus;
      minusIsPressed <= frame_minus;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: per-cycle model comparison plus
// directed scenarios with hand-computed expectations.
module tb_key_conditioner;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic keyPlusN = 1'b1;
  logic keyMinusN = 1'b1;
  logic plusIsPressed, minusIsPressed, plusPulse, minusPulse;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  logic sof_burst = 1'b0;

  key_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .keyPlusN       (keyPlusN),
    .keyMinusN      (keyMinusN),
    .plusIsPressed  (plusIsPressed),
    .minusIsPressed (minusIsPressed),
    .plusPulse      (plusPulse),
    .minusPulse     (minusPulse)
  );

  initial forever #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  // Model: a key is accepted once the last DEB synchronized samples all
  // disagree with the accepted level; samples lag the pin by two edges.
  logic [DEB+1:0] hp = '0, hm = '0;
  logic m_deb_p = 0, m_deb_m = 0, m_rise_p = 0, m_rise_m = 0;
  logic m_own_minus = 0, m_st_p = 0, m_st_m = 0;
  logic m_out_p = 0, m_out_m = 0, m_pul_p = 0, m_pul_m = 0;

  task automatic model_edge();
    logic n_deb_p, n_deb_m, ap, am, wp, wm;
    hp = {hp[DEB:0], ~keyPlusN};
    hm = {hm[DEB:0], ~keyMinusN};
    n_deb_p = (hp[DEB+1:2] == {DEB{~m_deb_p}}) ? ~m_deb_p : m_deb_p;
    n_deb_m = (hm[DEB+1:2] == {DEB{~m_deb_m}}) ? ~m_deb_m : m_deb_m;
    if (startOfFrame) begin
      ap = m_deb_p && (!m_deb_m || !m_own_minus);
      am = m_deb_m && (!m_deb_p || m_own_minus);
      wp = ap || (m_st_p && !am);
      wm = am || (m_st_m && !ap);
      if (wp && wm) begin
        wp = !m_own_minus;
        wm = m_own_minus;
      end
      m_out_p = wp;
      m_out_m = wm;
    end
    if (m_rise_p && !m_rise_m) m_own_minus = 1'b0;
    else if (m_rise_m && !m_rise_p) m_own_minus = 1'b1;
    m_st_p  = m_rise_p || (m_st_p && !startOfFrame);
    m_st_m  = m_rise_m || (m_st_m && !startOfFrame);
    m_pul_p = m_rise_p;
    m_pul_m = m_rise_m;
    m_rise_p = n_deb_p && !m_deb_p;
    m_rise_m = n_deb_m && !m_deb_m;
    m_deb_p = n_deb_p;
    m_deb_m = n_deb_m;
  endtask

  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      hp = '0; hm = '0;
      m_deb_p = 0; m_deb_m = 0; m_rise_p = 0; m_rise_m = 0;
      m_own_minus = 0; m_st_p = 0; m_st_m = 0;
      m_out_p = 0; m_out_m = 0; m_pul_p = 0; m_pul_m = 0;
    end else begin
      model_edge();
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    check("cmp_plusIsPressed", plusIsPressed, m_out_p);
    check("cmp_minusIsPressed", minusIsPressed, m_out_m);
    check("cmp_plusPulse", plusPulse, m_pul_p);
    check("cmp_minusPulse", minusPulse, m_pul_m);
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    startOfFrame = sof_burst || (cyc % 20 == 0);
  endtask

  task automatic wait_sof();
    int unsigned guard = 0;
    do begin
      step();
      guard++;
    end while (!startOfFrame && guard < 25);
    check("sof_seen", startOfFrame, 1'b1);
    step();
  endtask

  task automatic release_and_settle();
    keyPlusN = 1'b1;
    keyMinusN = 1'b1;
    repeat (45) step();
  endtask

  initial begin
    int unsigned pc;
    // Reset state
    repeat (2) step();
    check("rst_plusIsPressed", plusIsPressed, 1'b0);
    check("rst_minusIsPressed", minusIsPressed, 1'b0);
    check("rst_plusPulse", plusPulse, 1'b0);
    check("rst_minusPulse", minusPulse, 1'b0);
    resetN = 1'b1;
    step();

    // Clean press
    keyPlusN = 1'b0;
    repeat (6) step();
    check("clean_pulse_e6", plusPulse, 1'b0);
    step();
    check("clean_pulse_e7", plusPulse, 1'b1);
    step();
    check("clean_pulse_e8", plusPulse, 1'b0);
    wait_sof();
    check("clean_plus_level", plusIsPressed, 1'b1);
    check("clean_minus_level", minusIsPressed, 1'b0);
    release_and_settle();
    check("clean_release_level", plusIsPressed, 1'b0);

    // Bounce
    for (int i = 0; i < 10; i++) begin
      keyPlusN = (i % 2 != 0);
      repeat (2) begin
        step();
        check("bounce_no_pulse", plusPulse, 1'b0);
      end
    end
    keyPlusN = 1'b0;
    repeat (6) step();
    check("bounce_pulse_e6", plusPulse, 1'b0);
    step();
    check("bounce_pulse_e7", plusPulse, 1'b1);
    release_and_settle();

    // Short tap inside one frame
    wait_sof();
    step();
    keyMinusN = 1'b0;
    pc = 0;
    repeat (8) begin
      step();
      if (minusPulse === 1'b1) pc++;
    end
    keyMinusN = 1'b1;
    check("tap_pulse_count", pc, 1);
    wait_sof();
    check("tap_minus_frame1", minusIsPressed, 1'b1);
    check("tap_plus_frame1", plusIsPressed, 1'b0);
    wait_sof();
    check("tap_minus_frame2", minusIsPressed, 1'b0);
    release_and_settle();

    // Overlap: last pressed wins, release returns to the held key
    keyPlusN = 1'b0;
    repeat (30) step();
    keyMinusN = 1'b0;
    repeat (8) step();
    wait_sof();
    check("ovl_minus_level", minusIsPressed, 1'b1);
    check("ovl_plus_level", plusIsPressed, 1'b0);
    keyMinusN = 1'b1;
    repeat (8) step();
    wait_sof();
    check("ovl_back_plus", plusIsPressed, 1'b1);
    check("ovl_back_minus", minusIsPressed, 1'b0);
    release_and_settle();

    // Simultaneous press straight out of reset
    resetN = 1'b0;
    repeat (3) step();
    resetN = 1'b1;
    keyPlusN = 1'b0;
    keyMinusN = 1'b0;
    repeat (6) step();
    check("sim_plus_pulse_e6", plusPulse, 1'b0);
    step();
    check("sim_plus_pulse_e7", plusPulse, 1'b1);
    check("sim_minus_pulse_e7", minusPulse, 1'b1);
    wait_sof();
    check("sim_plus_level", plusIsPressed, 1'b1);
    check("sim_minus_level", minusIsPressed, 1'b0);
    release_and_settle();

    // Reset while plus is held and accepted
    keyPlusN = 1'b0;
    repeat (10) step();
    wait_sof();
    check("rmp_before_level", plusIsPressed, 1'b1);
    resetN = 1'b0;
    #1;
    check("rmp_async_level", plusIsPressed, 1'b0);
    check("rmp_async_pulse", plusPulse, 1'b0);
    repeat (3) begin
      step();
      check("rmp_in_reset_plus", plusIsPressed, 1'b0);
      check("rmp_in_reset_minus", minusIsPressed, 1'b0);
    end
    resetN = 1'b1;
    repeat (6) step();
    check("rmp_pulse_e6", plusPulse, 1'b0);
    step();
    check("rmp_pulse_e7", plusPulse, 1'b1);
    wait_sof();
    check("rmp_after_level", plusIsPressed, 1'b1);

    // startOfFrame on every clock while minus overtakes the held plus
    sof_burst = 1'b1;
    startOfFrame = 1'b1;
    keyMinusN = 1'b0;
    repeat (7) step();
    check("burst_e7_plus", plusIsPressed, 1'b1);
    check("burst_e7_minus", minusIsPressed, 1'b0);
    step();
    check("burst_e8_plus", plusIsPressed, 1'b0);
    check("burst_e8_minus", minusIsPressed, 1'b1);
    sof_burst = 1'b0;
    release_and_settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
